pwm_capture: RTL and testbench
==============================

// Module: pwm_capture
// PURPOSE
//  Measures an incoming PWM waveform: high time and period, in clk cycles.
//  Receive-side counterpart of the LED pwm driver; one instance per channel.
//  Used for loopback self-test of LED_R/G/B and for external PWM inputs.
//  Reports a fresh (high, period) pair once per completed period.
// PARAMETERS
//  CNT_W    16   width of high/period counters and outputs; saturate at 2^CNT_W-1
// PORTS
//  clk       in   1      system clock
//  rst       in   1      asynchronous reset, active-low
//  pwm_in    in   1      asynchronous PWM input, synchronised internally
//  high_cnt  out  CNT_W  clk cycles pwm_in was high in last complete period
//  period    out  CNT_W  clk cycles from rising edge to next rising edge
//  valid     out  1      one-cycle strobe: high_cnt/period just updated
//  stuck     out  1      no rising edge seen within 2^CNT_W-1 cycles
// BEHAVIOUR
//  - Reset (rst=0, async): high_cnt=0, period=0, valid=0, stuck=0, FSM=IDLE,
//    counters=0, synchroniser flops=0.
//  - Input path: 2-FF synchroniser, then 1 history flop; rise = s2 & ~s3.
//  - FSM IDLE: wait for rise -> MEAS; counters cleared, no valid (first period
//    after reset/stuck is discarded as incomplete).
//  - FSM MEAS, every cycle: per_c += 1; hi_c += 1 while synced level is high.
//    On rise: high_cnt<=hi_c, period<=per_c (both include current cycle
//    convention: period = exact edge-to-edge cycle count), valid<=1 for one
//    cycle, stuck<=0; counters restart at 1 (rise cycle counts), hi_c=1.
//  - Latency: valid asserts on the 3rd clk edge after the first edge that
//    samples pwm_in high at the synchroniser input.
//  - Saturation: per_c reaching 2^CNT_W-1 without rise -> stuck<=1,
//    high_cnt<=all-ones if level high else 0, period<=all-ones, valid pulse,
//    FSM -> IDLE. stuck clears only on next valid measurement.
//  - 0% / 100% duty: no rises -> stuck path, high_cnt reports 0 / all-ones.
//  - hi_c never exceeds per_c; no wrap-around anywhere (saturating only).
//  - Outputs hold last value between valid strobes; reset mid-period discards.
// CONFIGURATION
//  GLITCH_FILTER_EN defined: after synchroniser, level accepted only after
//    2 consecutive equal samples; pulses/gaps of 1 clk are ignored; adds 2 clk
//    to valid latency; counts use the filtered level.
//  GLITCH_FILTER_EN undefined: raw synchronised level used, 1-clk pulses count.
// TESTING
//  1. Drive from pwm #(8), max=255, threshold=64 -> after 1st discarded period,
//     valid every 256 clk, high_cnt=64, period=256, stuck=0.
//  2. threshold 0 then hold pwm_in=0, CNT_W=8 -> after 255 idle clk: stuck=1,
//     high_cnt=0, period=255, one valid pulse; FSM idle.
//  3. Hold pwm_in=1 (CNT_W=8) -> stuck=1, high_cnt=255, period=255; then resume
//     threshold=128 -> 2nd period valid with high_cnt=128, stuck=0.
//  4. Assert rst mid-period (period 256, high 200) -> all outputs 0 immediately;
//     first valid only after two further rising edges.
//  5. 1-clk glitch inserted in low phase, period 256 high 64: with
//     GLITCH_FILTER_EN high_cnt=64 period=256; without: extra rise, short
//     periods reported.
//  6. Valid latency: single rise after measuring -> valid on 3rd clk edge
//     (5th with GLITCH_FILTER_EN).

Source files
------------

// File: rtl/pwm_capture.sv
// PWM input capture: reports high time and period per completed PWM period.
// Optional GLITCH_FILTER_EN drops 1-clk pulses/gaps after the synchroniser.
module pwm_capture #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             stuck
);

    localparam logic [CNT_W-1:0] MAX  = '1;
    localparam logic [CNT_W-1:0] ZERO = '0;
    localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE,
        MEAS
    } state_t;

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;
    logic lvl;
    logic rise;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             stuck_q, stuck_d;

`ifdef GLITCH_FILTER_EN
    logic filt_q, filt_d;
    logic fh_q, fh_d;

    always_comb begin
        filt_d = (s2_q == s3_q) ? s2_q : filt_q;
        fh_d   = filt_q;
        lvl    = filt_q;
        rise   = filt_q & ~fh_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_q <= 1'b0;
            fh_q   <= 1'b0;
        end else begin
            filt_q <= filt_d;
            fh_q   <= fh_d;
        end
    end
`else
    always_comb begin
        lvl  = s2_q;
        rise = s2_q & ~s3_q;
    end
`endif

    always_comb begin
        s1_d = pwm_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // The rise cycle is the first cycle of the new period, so restarts load 1.
    always_comb begin
        state_d  = state_q;
        per_d    = per_q;
        hi_d     = hi_q;
        high_d   = high_q;
        period_d = period_q;
        valid_d  = 1'b0;
        stuck_d  = stuck_q;
        unique case (state_q)
            IDLE: begin
                per_d = ZERO;
                hi_d  = ZERO;
                if (rise) begin
                    state_d = MEAS;
                    per_d   = ONE;
                    hi_d    = ONE;
                end
            end
            MEAS: begin
                if (rise) begin
                    high_d   = hi_q;
                    period_d = per_q;
                    valid_d  = 1'b1;
                    stuck_d  = 1'b0;
                    per_d    = ONE;
                    hi_d     = ONE;
                end else if (per_q == MAX) begin
                    high_d   = lvl ? MAX : ZERO;
                    period_d = MAX;
                    valid_d  = 1'b1;
                    stuck_d  = 1'b1;
                    state_d  = IDLE;
                    per_d    = ZERO;
                    hi_d     = ZERO;
                end else begin
                    per_d = per_q + ONE;
                    hi_d  = hi_q + {{(CNT_W-1){1'b0}}, lvl};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            state_q  <= IDLE;
            per_q    <= ZERO;
            hi_q     <= ZERO;
            high_q   <= ZERO;
            period_q <= ZERO;
            valid_q  <= 1'b0;
            stuck_q  <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
            state_q  <= state_d;
            per_q    <= per_d;
            hi_q     <= hi_d;
            high_q   <= high_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            stuck_q  <= stuck_d;
        end
    end

    assign high_cnt = high_q;
    assign period   = period_q;
    assign valid    = valid_q;
    assign stuck    = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Randomised bench for pwm_capture with a queue-based reference model.
// Expected reports are derived from the sampled level stream between rises.
module tb_pwm_capture;

    localparam int CNT_W = 10;
    localparam int MAX   = (1 << CNT_W) - 1;
`ifdef GLITCH_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    typedef struct {
        int hi;
        int per;
        int stk;
    } rep_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pwm_in = 1'b0;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] period;
    logic             valid;
    logic             stuck;

    int checks = 0;
    int errors = 0;

    rep_t exp_q[$];
    bit   lq[$];
    bit   armed = 0;
    bit   xprev = 0;
    bit   fprev = 0;
    bit   lprev = 0;
    int   last_hi = 0;
    int   last_per = 0;
    int   last_stk = 0;

    pwm_capture #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst_n),
        .pwm_in  (pwm_in),
        .high_cnt(high_cnt),
        .period  (period),
        .valid   (valid),
        .stuck   (stuck)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int ones();
        int s = 0;
        foreach (lq[i]) s += int'(lq[i]);
        return s;
    endfunction

    // Reference: a period is the list of levels from one rise up to the next.
    always @(posedge clk) begin
        bit x, lvl, rise;
        if (!rst_n) begin
            armed = 0;
            xprev = 0;
            fprev = 0;
            lprev = 0;
            lq.delete();
            exp_q.delete();
            last_hi = 0;
            last_per = 0;
            last_stk = 0;
        end else begin
            x = pwm_in;
`ifdef GLITCH_FILTER_EN
            lvl = (x == xprev) ? x : fprev;
            xprev = x;
            fprev = lvl;
`else
            lvl = x;
`endif
            rise = lvl && !lprev;
            lprev = lvl;
            if (rise) begin
                if (armed)
                    exp_q.push_back('{ones(), lq.size(), 0});
                armed = 1;
                lq.delete();
                lq.push_back(1'b1);
            end else if (armed) begin
                if (lq.size() == MAX) begin
                    exp_q.push_back('{lvl ? MAX : 0, MAX, 1});
                    armed = 0;
                    lq.delete();
                end else begin
                    lq.push_back(lvl);
                end
            end
        end
    end

    always @(negedge clk) begin
        rep_t r;
        if (!rst_n) begin
            check("rst_hi", high_cnt, 0);
            check("rst_per", period, 0);
            check("rst_valid", valid, 0);
            check("rst_stuck", stuck, 0);
        end else if (valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", valid, 0);
            end else begin
                r = exp_q.pop_front();
                check("rep_hi", high_cnt, r.hi);
                check("rep_per", period, r.per);
                check("rep_stuck", stuck, r.stk);
                last_hi = r.hi;
                last_per = r.per;
                last_stk = r.stk;
            end
        end else begin
            check("hold_hi", high_cnt, last_hi);
            check("hold_per", period, last_per);
            check("hold_stuck", stuck, last_stk);
        end
    end

    task automatic run(input bit v, input int n);
        for (int i = 0; i < n; i++) begin
            pwm_in = v;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pwm(input int per, input int hi, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            run(1'b1, hi);
            run(1'b0, per - hi);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_now_hi", high_cnt, 0);
        check("rst_now_per", period, 0);
        check("rst_now_valid", valid, 0);
        check("rst_now_stuck", stuck, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run(1'b0, 20);

        pwm(256, 64, 4);
        check("t1_hi", high_cnt, 64);
        check("t1_per", period, 256);
        check("t1_stuck", stuck, 0);

        for (int i = 0; i < 12; i++) begin
            int p, h;
            p = $urandom_range(300, 8);
            h = $urandom_range(p - 2, 2);
            pwm(p, h, $urandom_range(3, 1));
        end

        pwm(256, 64, 2);
        run(1'b0, MAX + 20);
        check("t2_stuck", stuck, 1);
        check("t2_hi", high_cnt, 0);
        check("t2_per", period, MAX);

        pwm(200, 50, 2);
        run(1'b1, MAX + 20);
        check("t3_stuck", stuck, 1);
        check("t3_hi", high_cnt, MAX);
        pwm(256, 128, 3);
        check("t3r_hi", high_cnt, 128);
        check("t3r_per", period, 256);
        check("t3r_stuck", stuck, 0);

        pwm(256, 200, 2);
        run(1'b1, 100);
        do_reset();
        run(1'b1, 100);
        run(1'b0, 56);
        pwm(256, 200, 3);
        check("t4_hi", high_cnt, 200);
        check("t4_per", period, 256);

        for (int i = 0; i < 4; i++) begin
            run(1'b1, 64);
            run(1'b0, 100);
            run(1'b1, 1);
            run(1'b0, 91);
        end
        pwm(256, 64, 1);

        run(1'b1, 5);
        run(1'b0, 30);
        pwm_in = 1'b1;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid) begin
                lat = k;
                break;
            end
        end
        check("latency", lat, LAT);
        @(posedge clk);
        #1;
        run(1'b1, 10);
        run(1'b0, 10);

        for (int i = 0; i < 80; i++)
            run(1'(($urandom >> 3) & 1), $urandom_range(6, 1));
        for (int i = 0; i < 6; i++) begin
            int p, h;
            p = $urandom_range(900, 100);
            h = $urandom_range(p - 3, 3);
            pwm(p, h, 2);
        end

        run(1'b0, 12);
        check("drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
